decoder_round_controller: RTL
=============================

# decoder_round_controller

Sequencer for one decoding round of the single-FPGA X-stabilizer decoder grid (default 2 rows × 3 columns). It accepts a syndrome frame over a valid/ready handshake and drives the grid's measurement load. It then runs the settle and offer phases with `start_offer`/`stop_offer` pulses and captures the per-stabilizer `match_value` words after the offer window. The result is returned over a second valid/ready handshake. It replaces hand-timed stimulus with a reusable round scheduler between the host interface and the grid top.

## Interface
- `ROWS`, 2, stabilizer rows
- `COLS`, 3, stabilizer columns
- `CORDINATE_WIDTH`, 3, bits per coordinate
- `MATCH_VALUE_WIDTH`, 6, equals 2×`CORDINATE_WIDTH`; layout {y, x}
- `SETTLE_CYCLES`, 100, idle cycles between load and `start_offer` (≥1)
- `OFFER_CYCLES`, 2500, cycles between `start_offer` and `stop_offer` (≥1)
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low; 0 resets on the next edge
- `syndrome_in` in ROWS*COLS: bit r*COLS+c = stabilizer (r,c)
- `syndrome_valid` in 1: syndrome frame offered
- `syndrome_ready` out 1: controller accepts a frame
- `measurement_value_out` out ROWS*COLS: to grid `measurement_value_in_r_c`
- `measurement_valid_out` out 1: to every grid `measurement_valid_in_r_c`
- `start_offer` out 1: one-cycle pulse to grid
- `stop_offer` out 1: one-cycle pulse to grid
- `match_value_in` in ROWS*COLS*MATCH_VALUE_WIDTH: from grid `match_value_out_r_c`, slice index r*COLS+c
- `result_valid` out 1: result held stable until accepted
- `result_ready` in 1: consumer accepts result
- `result_match` out ROWS*COLS*MATCH_VALUE_WIDTH: captured matches, zero where syndrome bit is 0
- `result_syndrome` out ROWS*COLS: echo of accepted frame
- `round_count` out 16: completed rounds, wraps 0xFFFF→0
- `busy` out 1: state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, SETTLE, START, OFFER, STOP, CAPTURE, OUTPUT.
- IDLE:
  - `syndrome_ready`=1.
  - On `syndrome_valid`&&`syndrome_ready`, latch `syndrome_in`.
  - If the frame is nonzero → LOAD; if it is all-zero → OUTPUT directly with `result_match`=0. This fast path issues no grid pulses.
- LOAD: `measurement_valid_out`=1 for exactly one cycle. Clear the counter → SETTLE.
- SETTLE: count SETTLE_CYCLES cycles → START.
- START: `start_offer`=1 for one cycle. Clear the counter → OFFER.
- OFFER: count OFFER_CYCLES cycles → STOP.
- STOP: `stop_offer`=1 for one cycle → CAPTURE.
- CAPTURE:
  - Register `match_value_in` masked per stabilizer by the latched syndrome.
  - Increment `round_count` → OUTPUT.
  - The fast path also increments `round_count` on its IDLE→OUTPUT transition.
- OUTPUT:
  - `result_valid`=1; `result_*` stable.
  - On `result_ready` → IDLE.
- Counter: a single down-counter, width $clog2(max(SETTLE_CYCLES,OFFER_CYCLES)+1).
- `measurement_value_out` holds the latched syndrome from LOAD until the next accept. It is 0 after reset.

## Timing
- Reset values:
  - state IDLE; all outputs 0 except `syndrome_ready`=1.
  - `round_count`=0, `result_match`=0, `result_syndrome`=0.
- Reset mid-round: the controller returns to IDLE on the next edge. No `stop_offer` is issued and the in-flight round is discarded.
- Accept at edge T (nonzero frame):
  - `measurement_valid_out` high in cycle T+1.
  - `start_offer` high in cycle T+2+SETTLE_CYCLES.
  - `stop_offer` high in cycle T+3+SETTLE_CYCLES+OFFER_CYCLES.
  - `result_valid` rises at T+5+SETTLE_CYCLES+OFFER_CYCLES.
- Fast path: `result_valid` rises at T+1.
- Return to IDLE:
  - `result_valid`&&`result_ready` at edge E → IDLE at E.
  - `syndrome_ready` is high in the following cycle; there is no same-cycle accept overlap.
- `syndrome_valid` while busy is ignored (ready=0); the producer must hold it.
- `result_ready` asserted before `result_valid` has no effect.
- All grid-facing outputs are registered.

## Structure
- Shared package `decoder_pkg`:
  - state enum
  - `MATCH_VALUE_WIDTH`/`CORDINATE_WIDTH` constants
  - `match_y()`/`match_x()` field-extract functions
- One sub-module `phase_counter`: loadable down-counter with a `done` flag, reused for SETTLE and OFFER.
- Instantiation: `decoder_round_controller` wraps around `top_single_3_by_3_x` in the system top. The grid ports map one-to-one.

## Test plan
- Reset: hold `reset`=0 for 10 cycles → all outputs at reset values, `syndrome_ready`=1.
- Pulse timing: frame 6'b000011 with SETTLE_CYCLES=100, OFFER_CYCLES=2500.
  - `measurement_valid_out` pulses at T+1, `start_offer` at T+102, `stop_offer` at T+2603.
  - `result_valid` at T+2605.
- Capture masking: frame 6'b000011 with a grid model driving (0,0)→{0,1}, (0,1)→{0,0}, all others 6'h3F.
  - `result_match` slices 0 and 1 are 6'o01 and 6'o00; slices 2–5 are 0.
  - `round_count`=1.
- Zero frame: accept frame 0 → no grid pulses, `result_valid` at T+1 with all-zero match, `round_count` increments.
- Backpressure: hold `result_ready`=0 for 50 cycles → result stable, `syndrome_ready`=0, and a second frame stays unaccepted until release.
- Reset mid-round and wrap:
  - Assert `reset` during OFFER → no `stop_offer`, state IDLE.
  - Preload `round_count` via 65536 fast-path rounds → wraps to 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder round controller.
// The match word layout is {y, x}, with one coordinate per field.
package decoder_pkg;

    localparam int CORDINATE_WIDTH   = 3;
    localparam int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_START,
        ST_OFFER,
        ST_STOP,
        ST_CAPTURE,
        ST_OUTPUT
    } state_t;

    function automatic logic [CORDINATE_WIDTH-1:0] match_y(input logic [MATCH_VALUE_WIDTH-1:0] mv);
        return mv[MATCH_VALUE_WIDTH-1:CORDINATE_WIDTH];
    endfunction

    function automatic logic [CORDINATE_WIDTH-1:0] match_x(input logic [MATCH_VALUE_WIDTH-1:0] mv);
        return mv[CORDINATE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/decoder_round_controller_phase_counter.sv
// Loadable down-counter that times both the settle window and the offer window.
// The counter saturates at zero, and o_done reflects terminal count.
module phase_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/decoder_round_controller.sv
// Sequencer for one decoding round: it loads the grid, runs the settle and offer
// phases, captures the masked matches, and hands the result to the host.
//
// state      | meaning
// IDLE       | ready for a syndrome frame
// LOAD       | measurement_valid_out pulse to grid
// SETTLE     | wait SETTLE_CYCLES before offering
// START      | start_offer pulse
// OFFER      | offer window of OFFER_CYCLES
// STOP       | stop_offer pulse
// CAPTURE    | register masked match words, count round
// OUTPUT     | result held until result_ready
module decoder_round_controller #(
    parameter int ROWS              = 2,
    parameter int COLS              = 3,
    parameter int CORDINATE_WIDTH   = 3,
    parameter int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH,
    parameter int SETTLE_CYCLES     = 100,
    parameter int OFFER_CYCLES      = 2500
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ROWS*COLS-1:0]                   syndrome_in,
    input  logic                                   syndrome_valid,
    output logic                                   syndrome_ready,
    output logic [ROWS*COLS-1:0]                   measurement_value_out,
    output logic                                   measurement_valid_out,
    output logic                                   start_offer,
    output logic                                   stop_offer,
    input  logic [ROWS*COLS*MATCH_VALUE_WIDTH-1:0] match_value_in,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [ROWS*COLS*MATCH_VALUE_WIDTH-1:0] result_match,
    output logic [ROWS*COLS-1:0]                   result_syndrome,
    output logic [15:0]                            round_count,
    output logic                                   busy
);

    import decoder_pkg::*;

    localparam int N_STAB  = ROWS * COLS;
    localparam int MW      = MATCH_VALUE_WIDTH;
    localparam int CNT_MAX = (SETTLE_CYCLES > OFFER_CYCLES) ? SETTLE_CYCLES : OFFER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_cnt_load;
    logic [CNT_W-1:0]      w_cnt_value;
    logic                  w_cnt_dec;
    logic                  w_cnt_done;

    logic [N_STAB-1:0]     r_syndrome;
    logic [N_STAB*MW-1:0]  r_result_match;
    logic [15:0]           r_round_count;
    logic                  r_meas_valid;
    logic                  r_start;
    logic                  r_stop;
    logic                  r_result_valid;
    logic                  r_busy;
    logic                  r_syn_ready;

    phase_counter #(
        .WIDTH(CNT_W)
    ) u_phase_counter (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_cnt_load),
        .i_load_value(w_cnt_value),
        .i_dec       (w_cnt_dec),
        .o_done      (w_cnt_done)
    );

    assign w_accept = (r_state == ST_IDLE) && syndrome_valid;

    always_comb begin
        w_next      = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_value = '0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (syndrome_valid) begin
                    w_next = (syndrome_in != '0) ? ST_LOAD : ST_OUTPUT;
                end
            end
            ST_LOAD: begin
                w_cnt_load  = 1'b1;
                w_cnt_value = CNT_W'(SETTLE_CYCLES - 1);
                w_next      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_cnt_done) w_next = ST_START;
                else            w_cnt_dec = 1'b1;
            end
            ST_START: begin
                w_cnt_load  = 1'b1;
                w_cnt_value = CNT_W'(OFFER_CYCLES - 1);
                w_next      = ST_OFFER;
            end
            ST_OFFER: begin
                if (w_cnt_done) w_next = ST_STOP;
                else            w_cnt_dec = 1'b1;
            end
            ST_STOP:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_OUTPUT;
            ST_OUTPUT: begin
                if (result_ready) w_next = ST_IDLE;
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every grid-facing signal is a flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_syndrome     <= '0;
            r_result_match <= '0;
            r_round_count  <= '0;
            r_meas_valid   <= 1'b0;
            r_start        <= 1'b0;
            r_stop         <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_syn_ready    <= 1'b1;
        end else begin
            r_state        <= w_next;
            r_meas_valid   <= (w_next == ST_LOAD);
            r_start        <= (w_next == ST_START);
            r_stop         <= (w_next == ST_STOP);
            r_result_valid <= (w_next == ST_OUTPUT);
            r_busy         <= (w_next != ST_IDLE);
            r_syn_ready    <= (w_next == ST_IDLE);
            if (w_accept) begin
                r_syndrome <= syndrome_in;
                if (syndrome_in == '0) begin
                    r_result_match <= '0;
                    r_round_count  <= r_round_count + 16'd1;
                end
            end
            if (r_state == ST_CAPTURE) begin
                for (int i = 0; i < N_STAB; i++) begin
                    r_result_match[i*MW +: MW] <= r_syndrome[i] ? match_value_in[i*MW +: MW] : '0;
                end
                r_round_count <= r_round_count + 16'd1;
            end
        end
    end

    assign syndrome_ready        = r_syn_ready;
    assign measurement_value_out = r_syndrome;
    assign measurement_valid_out = r_meas_valid;
    assign start_offer           = r_start;
    assign stop_offer            = r_stop;
    assign result_valid          = r_result_valid;
    assign result_match          = r_result_match;
    assign result_syndrome       = r_syndrome;
    assign round_count           = r_round_count;
    assign busy                  = r_busy;

endmodule
